// File: rtl/jesd204b_tx_pkg.sv
// rtl/jesd204b_tx_pkg.sv - JESD204B TX link-layer control characters, ILA config record and config-octet helper
package jesd204b_tx_pkg;

    localparam logic [7:0] K28_0 = 8'h1C;
    localparam logic [7:0] K28_3 = 8'h7C;
    localparam logic [7:0] K28_4 = 8'h9C;
    localparam logic [7:0] K28_5 = 8'hBC;

    localparam logic [2:0] SUBCLASSV_DEFAULT = 3'd1;
    localparam logic [2:0] JESDV_DEFAULT     = 3'd1;

    localparam logic [3:0] CFG_C0  = 4'd0;
    localparam logic [3:0] CFG_C1  = 4'd1;
    localparam logic [3:0] CFG_C2  = 4'd2;
    localparam logic [3:0] CFG_C3  = 4'd3;
    localparam logic [3:0] CFG_C4  = 4'd4;
    localparam logic [3:0] CFG_C5  = 4'd5;
    localparam logic [3:0] CFG_C6  = 4'd6;
    localparam logic [3:0] CFG_C7  = 4'd7;
    localparam logic [3:0] CFG_C8  = 4'd8;
    localparam logic [3:0] CFG_C9  = 4'd9;
    localparam logic [3:0] CFG_C10 = 4'd10;
    localparam logic [3:0] CFG_C11 = 4'd11;
    localparam logic [3:0] CFG_C12 = 4'd12;
    localparam logic [3:0] CFG_C13 = 4'd13;

    localparam logic [7:0]  ILA_MIN_LEN       = 8'd3;
    localparam logic [13:0] ILA_MIN_MF_OCTETS = 14'd17;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_GEN  = 1'b1
    } ila_state_t;

    typedef struct packed {
        logic [7:0] did;
        logic [3:0] bid;
        logic [4:0] lid_base;
        logic [3:0] adjcnt;
        logic       adjdir;
        logic       phadj;
        logic       scr;
        logic [4:0] l;
        logic [7:0] f;
        logic [4:0] k;
        logic [7:0] m;
        logic [1:0] cs;
        logic [4:0] n;
        logic [4:0] n_ap;
        logic [4:0] s;
        logic       hd;
        logic [4:0] cf;
    } ila_cfg_t;

    // Octets c0..c12 of one lane; c13 (FCHK) is formed by the caller from these.
    function automatic logic [7:0] ila_cfg_byte(input ila_cfg_t cfg, input logic [2:0] subclassv,
                                                input logic [2:0] jesdv, input logic [2:0] lane,
                                                input logic [3:0] c);
        logic [4:0] lid;
        logic [7:0] b;
        lid = cfg.lid_base + {2'b00, lane};
        case (c)
            CFG_C0:  b = cfg.did;
            CFG_C1:  b = {cfg.adjcnt, cfg.bid};
            CFG_C2:  b = {1'b0, cfg.adjdir, cfg.phadj, lid};
            CFG_C3:  b = {cfg.scr, 2'b00, cfg.l};
            CFG_C4:  b = cfg.f;
            CFG_C5:  b = {3'b000, cfg.k};
            CFG_C6:  b = cfg.m;
            CFG_C7:  b = {cfg.cs, 1'b0, cfg.n};
            CFG_C8:  b = {subclassv, cfg.n_ap};
            CFG_C9:  b = {jesdv, cfg.s};
            CFG_C10: b = {cfg.hd, 2'b00, cfg.cf};
            CFG_C11, CFG_C12: b = 8'h00;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/ila_cfg_octet.sv
// rtl/ila_cfg_octet.sv - per-lane ILA configuration octet mux with FCHK
module ila_cfg_octet
    import jesd204b_tx_pkg::*;
#(
    parameter logic [2:0] SUBCLASSV = SUBCLASSV_DEFAULT,
    parameter logic [2:0] JESDV     = JESDV_DEFAULT
) (
    input  ila_cfg_t   cfg,
    input  logic [2:0] lane,
    input  logic [3:0] c,
    output logic [7:0] octet
);

    logic [7:0] fchk;

    always_comb begin
        fchk = 8'h00;
        for (int i = 0; i <= int'(CFG_C12); i++) begin
            fchk = fchk + ila_cfg_byte(cfg, SUBCLASSV, JESDV, lane, 4'(i));
        end
    end

    assign octet = (c == CFG_C13) ? fchk : ila_cfg_byte(cfg, SUBCLASSV, JESDV, lane, c);

endmodule

// File: rtl/ila_gen_multilane.sv
// rtl/ila_gen_multilane.sv - multi-lane JESD204B TX initial lane alignment sequence generator
module ila_gen_multilane
    import jesd204b_tx_pkg::*;
#(
    parameter int         LANES     = 4,
    parameter logic [2:0] SUBCLASSV = SUBCLASSV_DEFAULT,
    parameter logic [2:0] JESDV     = JESDV_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_seq_start,
    input  logic [7:0]         i_ila_multiframe_length,
    input  logic [7:0]         i_DID,
    input  logic [3:0]         i_BID,
    input  logic [4:0]         i_LID_base,
    input  logic [3:0]         i_adjcnt,
    input  logic               i_adjdir,
    input  logic               i_phadj,
    input  logic               i_SCR,
    input  logic [4:0]         i_L,
    input  logic [7:0]         i_F,
    input  logic [4:0]         i_K,
    input  logic [7:0]         i_M,
    input  logic [1:0]         i_CS,
    input  logic [4:0]         i_N,
    input  logic [4:0]         i_N_ap,
    input  logic [4:0]         i_S,
    input  logic               i_HD,
    input  logic [4:0]         i_CF,
    output logic [8*LANES-1:0] o_data,
    output logic [LANES-1:0]   o_k,
    output logic               o_vld,
    input  logic               i_rdy,
    output logic               o_busy,
    output logic               o_seq_end,
    output logic               o_cfg_err
);

    ila_state_t  state, state_n;
    ila_cfg_t    sh, cfg_in;
    logic [7:0]  sh_len, len_in;
    logic        prep;

    logic [7:0]  oct, oct_n;
    logic [4:0]  frm, frm_n;
    logic [7:0]  mf, mf_n;
    logic [12:0] mfi, mfi_n;
    logic [15:0] pos, pos_n;

    logic [8:0]  f_p1;
    logic [5:0]  k_p1;
    logic [13:0] fk_prod;
    logic        cfg_ok, start_ok, accept, advance, finish;

    logic        is_r, is_a, is_q, is_cfg, is_ctrl, beat_end;
    logic [7:0]  ctrl_char;
    logic [3:0]  cfg_idx;
    logic [7:0]  lane_cfg [LANES];
    logic [8*LANES-1:0] beat_data;

    assign f_p1     = {1'b0, i_F} + 9'd1;
    assign k_p1     = {1'b0, i_K} + 6'd1;
    assign fk_prod  = {5'b0, f_p1} * {8'b0, k_p1};
    assign cfg_ok   = fk_prod >= ILA_MIN_MF_OCTETS;
    assign start_ok = (state == ST_IDLE) && i_seq_start && cfg_ok;
    assign accept   = o_vld && i_rdy;
    // First GEN cycle loads the counters from the freshly latched shadow copy.
    assign advance  = (state == ST_GEN) && (prep || (accept && !o_seq_end));
    assign finish   = (state == ST_GEN) && !prep && accept && o_seq_end;
    assign len_in   = (i_ila_multiframe_length < ILA_MIN_LEN) ? ILA_MIN_LEN : i_ila_multiframe_length;

    always_comb begin
        cfg_in          = '0;
        cfg_in.did      = i_DID;
        cfg_in.bid      = i_BID;
        cfg_in.lid_base = i_LID_base;
        cfg_in.adjcnt   = i_adjcnt;
        cfg_in.adjdir   = i_adjdir;
        cfg_in.phadj    = i_phadj;
        cfg_in.scr      = i_SCR;
        cfg_in.l        = i_L;
        cfg_in.f        = i_F;
        cfg_in.k        = i_K;
        cfg_in.m        = i_M;
        cfg_in.cs       = i_CS;
        cfg_in.n        = i_N;
        cfg_in.n_ap     = i_N_ap;
        cfg_in.s        = i_S;
        cfg_in.hd       = i_HD;
        cfg_in.cf       = i_CF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (start_ok) state_n = ST_GEN;
            ST_GEN:  if (finish)   state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        oct_n = '0;
        frm_n = '0;
        mf_n  = '0;
        mfi_n = '0;
        pos_n = '0;
        if (!prep) begin
            pos_n = pos + 16'd1;
            mfi_n = mfi + 13'd1;
            oct_n = oct + 8'd1;
            frm_n = frm;
            mf_n  = mf;
            if (oct == sh.f) begin
                oct_n = '0;
                if (frm == sh.k) begin
                    frm_n = '0;
                    mfi_n = '0;
                    mf_n  = mf + 8'd1;
                end else begin
                    frm_n = frm + 5'd1;
                end
            end
        end
    end

    // Beat content for the counter values about to be registered.
    always_comb begin
        is_r     = (mfi_n == 13'd0);
        is_a     = (oct_n == sh.f) && (frm_n == sh.k);
        is_q     = (mf_n == 8'd1) && (mfi_n == 13'd1);
        is_cfg   = (mf_n == 8'd1) && (mfi_n >= 13'd2) && (mfi_n <= 13'd15);
        is_ctrl  = is_r || is_a || is_q;
        cfg_idx  = mfi_n[3:0] - 4'd2;
        beat_end = is_a && (mf_n == sh_len);
        if (is_r) begin
            ctrl_char = K28_0;
        end else if (is_a) begin
            ctrl_char = K28_3;
        end else begin
            ctrl_char = K28_4;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        ila_cfg_octet #(
            .SUBCLASSV(SUBCLASSV),
            .JESDV    (JESDV)
        ) u_cfg (
            .cfg  (sh),
            .lane (3'(g)),
            .c    (cfg_idx),
            .octet(lane_cfg[g])
        );
        assign beat_data[8*g +: 8] = is_ctrl ? ctrl_char : (is_cfg ? lane_cfg[g] : pos_n[7:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh        <= '0;
            sh_len    <= ILA_MIN_LEN;
            prep      <= 1'b0;
            oct       <= '0;
            frm       <= '0;
            mf        <= '0;
            mfi       <= '0;
            pos       <= '0;
            o_data    <= {LANES{K28_5}};
            o_k       <= '1;
            o_vld     <= 1'b1;
            o_busy    <= 1'b0;
            o_seq_end <= 1'b0;
            o_cfg_err <= 1'b0;
        end else begin
            o_vld     <= 1'b1;
            o_busy    <= (state_n == ST_GEN);
            o_cfg_err <= (state == ST_IDLE) && i_seq_start && !cfg_ok;
            if (start_ok) begin
                sh        <= cfg_in;
                sh_len    <= len_in;
                prep      <= 1'b1;
                oct       <= '0;
                frm       <= '0;
                mf        <= '0;
                mfi       <= '0;
                pos       <= '0;
                o_data    <= {LANES{K28_5}};
                o_k       <= '1;
                o_seq_end <= 1'b0;
            end else if (advance) begin
                prep      <= 1'b0;
                oct       <= oct_n;
                frm       <= frm_n;
                mf        <= mf_n;
                mfi       <= mfi_n;
                pos       <= pos_n;
                o_data    <= beat_data;
                o_k       <= {LANES{is_ctrl}};
                o_seq_end <= beat_end;
            end else if (finish) begin
                oct       <= '0;
                frm       <= '0;
                mf        <= '0;
                mfi       <= '0;
                pos       <= '0;
                o_data    <= {LANES{K28_5}};
                o_k       <= '1;
                o_seq_end <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ila_gen_multilane.sv
// tb/tb_ila_gen_multilane.sv - directed self-checking bench for ila_gen_multilane
module tb_ila_gen_multilane;
    import jesd204b_tx_pkg::*;

    localparam int LANES = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_seq_start;
    logic [7:0]  i_ila_multiframe_length;
    logic [7:0]  i_DID;
    logic [3:0]  i_BID;
    logic [4:0]  i_LID_base;
    logic [3:0]  i_adjcnt;
    logic        i_adjdir, i_phadj, i_SCR, i_HD;
    logic [4:0]  i_L, i_K, i_N, i_N_ap, i_S, i_CF;
    logic [7:0]  i_F, i_M;
    logic [1:0]  i_CS;
    logic [15:0] o_data;
    logic [1:0]  o_k;
    logic        o_vld, i_rdy, o_busy, o_seq_end, o_cfg_err;

    int tests  = 0;
    int failed = 0;

    logic [15:0] cap_data [$];
    logic [1:0]  cap_k    [$];
    logic        cap_end  [$];

    ila_gen_multilane #(.LANES(LANES)) dut (
        .clk(clk), .rst(rst), .i_seq_start(i_seq_start),
        .i_ila_multiframe_length(i_ila_multiframe_length),
        .i_DID(i_DID), .i_BID(i_BID), .i_LID_base(i_LID_base),
        .i_adjcnt(i_adjcnt), .i_adjdir(i_adjdir), .i_phadj(i_phadj),
        .i_SCR(i_SCR), .i_L(i_L), .i_F(i_F), .i_K(i_K), .i_M(i_M), .i_CS(i_CS),
        .i_N(i_N), .i_N_ap(i_N_ap), .i_S(i_S), .i_HD(i_HD), .i_CF(i_CF),
        .o_data(o_data), .o_k(o_k), .o_vld(o_vld), .i_rdy(i_rdy),
        .o_busy(o_busy), .o_seq_end(o_seq_end), .o_cfg_err(o_cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_cfg(input logic [7:0] len, input logic [7:0] f, input logic [4:0] k);
        i_ila_multiframe_length = len;
        i_DID = 8'h01; i_BID = 4'd2; i_LID_base = 5'd0;
        i_adjcnt = 4'd0; i_adjdir = 1'b0; i_phadj = 1'b0;
        i_SCR = 1'b0; i_L = 5'd1; i_F = f; i_K = k; i_M = 8'd1; i_CS = 2'd0;
        i_N = 5'd15; i_N_ap = 5'd15; i_S = 5'd0; i_HD = 1'b0; i_CF = 5'd0;
    endtask

    // Hand-computed config octets for the common config (lane 1 differs in c2 and c13).
    function automatic logic [7:0] exp_cfg(input int lane, input int c);
        logic [7:0] v;
        case (c)
            0: v = 8'h01;  1: v = 8'h02;  2: v = 8'h00;  3: v = 8'h01;
            4: v = 8'h01;  5: v = 8'h0F;  6: v = 8'h01;  7: v = 8'h0F;
            8: v = 8'h2F;  9: v = 8'h20;  13: v = 8'h73;
            default: v = 8'h00;
        endcase
        if (lane == 1 && (c == 2 || c == 13)) v = v + 8'd1;
        return v;
    endfunction

    // {k, octet} for beat b of a 4-multiframe ILA with 32 octets per multiframe.
    function automatic logic [8:0] exp_beat(input int b, input int lane);
        int mfi = b % 32;
        int mf  = b / 32;
        if (mfi == 0)  return {1'b1, 8'h1C};
        if (mfi == 31) return {1'b1, 8'h7C};
        if (mf == 1 && mfi == 1) return {1'b1, 8'h9C};
        if (mf == 1 && mfi >= 2 && mfi <= 15) return {1'b0, exp_cfg(lane, mfi - 2)};
        return {1'b0, 8'(b)};
    endfunction

    task automatic start_seq();
        @(negedge clk);
        i_seq_start = 1'b1;
        @(negedge clk);
        i_seq_start = 1'b0;
    endtask

    task automatic capture(input bit rnd, input int stop_at, output int first_cyc,
                           output int stall_bad, output bit timed_out);
        logic [15:0] pd;
        logic [1:0]  pk;
        logic        pe;
        bit          pstall, nr, is_ila, done;
        cap_data.delete(); cap_k.delete(); cap_end.delete();
        first_cyc = -1; stall_bad = 0; timed_out = 1'b1;
        pstall = 1'b0; done = 1'b0; pd = '0; pk = '0; pe = 1'b0;
        for (int cyc = 1; cyc <= 3000 && !done; cyc++) begin
            @(negedge clk);
            if (pstall && (o_data !== pd || o_k !== pk || o_seq_end !== pe)) stall_bad++;
            nr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            i_rdy = nr;
            is_ila = o_busy && !(o_k == 2'b11 && o_data == {K28_5, K28_5});
            if (is_ila && o_vld && nr) begin
                if (first_cyc < 0) first_cyc = cyc;
                cap_data.push_back(o_data);
                cap_k.push_back(o_k);
                cap_end.push_back(o_seq_end);
                if (o_seq_end || cap_data.size() == stop_at) begin
                    done = 1'b1;
                    timed_out = 1'b0;
                end
            end
            pstall = is_ila && o_vld && !nr;
            pd = o_data; pk = o_k; pe = o_seq_end;
        end
    endtask

    task automatic check_ila(input string tag);
        int          mism = 0;
        int          ends = 0;
        logic [15:0] d;
        logic [1:0]  k;
        check({tag, "_len"}, cap_data.size(), 128);
        foreach (cap_data[b]) begin
            d = cap_data[b];
            k = cap_k[b];
            for (int l = 0; l < LANES; l++) begin
                if ({k[l], d[8*l +: 8]} !== exp_beat(b, l)) mism++;
            end
            if (cap_end[b]) ends++;
        end
        check({tag, "_beat_mismatches"}, mism, 0);
        check({tag, "_seq_end_count"}, ends, 1);
        if (cap_end.size() > 0) check({tag, "_seq_end_last"}, cap_end[cap_end.size() - 1], 1);
    endtask

    initial begin
        int fc, sb;
        bit to;
        logic [15:0] d;

        rst = 1'b1; i_seq_start = 1'b0; i_rdy = 1'b1;
        set_cfg(8'd3, 8'd1, 5'd15);
        repeat (2) @(negedge clk);
        check("rst_data", o_data, 16'hBCBC);
        check("rst_k", o_k, 2'b11);
        check("rst_vld", o_vld, 1);
        check("rst_busy", o_busy, 0);
        check("rst_seq_end", o_seq_end, 0);
        check("rst_cfg_err", o_cfg_err, 0);
        rst = 1'b0;

        start_seq();
        check("prep_busy", o_busy, 1);
        check("prep_fill", o_data, 16'hBCBC);
        capture(1'b0, 0, fc, sb, to);
        check("basic_timeout", to, 0);
        check("basic_latency", fc, 1);
        check_ila("basic");
        if (cap_data.size() == 128) begin
            check("basic_r0", {cap_k[0], cap_data[0]}, {2'b11, 16'h1C1C});
            check("basic_a127", {cap_k[127], cap_data[127]}, {2'b11, 16'h7C7C});
            check("basic_q33", {cap_k[33], cap_data[33]}, {2'b11, 16'h9C9C});
            d = cap_data[42];
            check("basic_c8", d[7:0], 8'h2F);
            check("basic_c2", cap_data[36], 16'h0100);
            check("basic_fchk", cap_data[47], 16'h7473);
            check("basic_pos16", cap_data[16], 16'h1010);
        end
        @(negedge clk);
        check("basic_end_fill", o_data, 16'hBCBC);
        check("basic_end_busy", o_busy, 0);
        check("basic_end_seq_end", o_seq_end, 0);

        start_seq();
        capture(1'b1, 0, fc, sb, to);
        check("bp_timeout", to, 0);
        check_ila("bp");
        check("bp_stall_unstable", sb, 0);
        @(negedge clk);
        i_rdy = 1'b1;
        check("bp_end_fill", o_data, 16'hBCBC);

        set_cfg(8'd3, 8'd0, 5'd7);
        start_seq();
        check("rej_cfg_err", o_cfg_err, 1);
        check("rej_busy", o_busy, 0);
        check("rej_fill", o_data, 16'hBCBC);
        @(negedge clk);
        check("rej_cfg_err_pulse", o_cfg_err, 0);
        check("rej_busy2", o_busy, 0);

        set_cfg(8'd3, 8'd1, 5'd15);
        start_seq();
        capture(1'b0, 40, fc, sb, to);
        check("mrst_beats", cap_data.size(), 40);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_fill", o_data, 16'hBCBC);
        check("mrst_k", o_k, 2'b11);
        check("mrst_busy", o_busy, 0);
        check("mrst_seq_end", o_seq_end, 0);
        start_seq();
        capture(1'b0, 0, fc, sb, to);
        check("mrst_timeout", to, 0);
        check_ila("restart");

        set_cfg(8'd0, 8'd1, 5'd15);
        @(negedge clk);
        i_seq_start = 1'b1;
        @(negedge clk);
        capture(1'b0, 0, fc, sb, to);
        check("clamp_timeout", to, 0);
        check_ila("clamp");
        @(negedge clk);
        check("b2b_idle_fill", o_data, 16'hBCBC);
        check("b2b_idle_busy", o_busy, 0);
        @(negedge clk);
        check("b2b_restart_busy", o_busy, 1);
        @(negedge clk);
        check("b2b_first_r", {o_k, o_data}, {2'b11, 16'h1C1C});
        i_seq_start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
